mult_div_unit: RTL

- Multicycle signed multiply/divide unit for the MIPS-subset datapath.
- Produces the HI and LO registers. These are inputs of the register-write-back source mux that drives the register bank write-data port.
- The control FSM pulses `start` on MULT/DIV and then stalls until `done`. MFHI/MFLO later route `hi`/`lo` through the write-back mux.

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply / restoring divide unit producing HI and LO.
// Define MULTDIV_UNSIGNED_EN to enable MULTU/DIVU through op[1].
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             accept, is_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  assign accept = (state_q == IDLE) && start;

`ifdef MULTDIV_UNSIGNED_EN
  assign is_signed = ~op[1];
`else
  logic unused_op1;
  assign is_signed  = 1'b1;
  assign unused_op1 = op[1];
`endif

  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FINISH);
  end

  // One iteration step: shift-add for mult, restoring shift-subtract for div.
  always_comb begin
    add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      nxt_hi = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo_q[WIDTH-2:0], rem_ge};
    end else begin
      nxt_hi = add_sum[WIDTH:1];
      nxt_lo = {add_sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    if (is_div_q) begin
      res_lo = neg_q  ? -nxt_lo : nxt_lo;
      res_hi = rneg_q ? -nxt_hi : nxt_hi;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // A zero divisor makes one idle pass through RUN so done lands two cycles after accept.
  always_comb begin
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      is_div_d   = op[0];
      dz_d       = op[0] & b_zero;
      div_zero_d = op[0] & b_zero;
      neg_d      = a_neg ^ b_neg;
      rneg_d     = a_neg;
      cnt_d      = (op[0] & b_zero) ? '0 : CNT_LAST;
      opnd_d     = op[0] ? b_mag : a_mag;
      acc_hi_d   = '0;
      acc_lo_d   = op[0] ? a_mag : b_mag;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (!dz_q) begin
        acc_hi_d = nxt_hi;
        acc_lo_d = nxt_lo;
        if (cnt_q == '0) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
